barrel_shifter_pipe: RTL

- Parametrised, pipelined successor to the combinational ARM operand-2 barrel shifter.
- Supports LSL/LSR/ASR/ROR/RRX with ARM-correct carry-out for both immediate-specified and register-specified shift amounts, at any power-of-two WIDTH.
- Adds a valid/ready handshake and STAGES register stages with full backpressure.
- Sits between the register-file read and the ALU operand-2 input of the multi-cycle/pipelined CPU datapath.

---
 rtl/barrel_shifter_pipe_pkg.sv | 14 +
 rtl/barrel_shifter_pipe_decode.sv | 78 +++++++
 rtl/barrel_shifter_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared op/form encodings for the pipelined ARM operand-2 shifter.
package arm_shift_pkg;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_op_e;

   localparam logic FORM_IMM = 1'b0;
   localparam logic FORM_REG = 1'b1;

endpackage

// File: rtl/barrel_shifter_pipe_decode.sv
// Stage-1 decode: effective shift amount and resolution of every special case
// (zero amount, RRX, amount >= WIDTH) into a ready-made bypass result.
module shift_decode
   import arm_shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NUM_W = 8
) (
   input  logic [WIDTH-1:0]         i_data,
   input  logic [NUM_W-1:0]         i_num,
   input  logic [2:0]               i_op,
   input  logic                     i_cf,
   output logic                     o_bypass,
   output logic [WIDTH-1:0]         o_byp_data,
   output logic                     o_byp_carry,
   output logic [$clog2(WIDTH)-1:0] o_amount
);

   localparam int L = $clog2(WIDTH);
   localparam logic [NUM_W-1:0] W_N = NUM_W'(WIDTH);

   shift_op_e        w_op;
   logic             w_reg;
   logic             w_msb;
   logic [NUM_W-1:0] w_n;
   logic [L-1:0]     w_r;

   assign w_op  = shift_op_e'(i_op[2:1]);
   assign w_reg = (i_op[0] == FORM_REG);
   assign w_msb = i_data[WIDTH-1];
   assign w_n   = w_reg ? i_num : {{(NUM_W-L){1'b0}}, i_num[L-1:0]};
   assign w_r   = w_n[L-1:0];

   // o_amount is a right-rotate count; LSL rotates right by WIDTH-n
   always_comb begin
      o_bypass    = 1'b1;
      o_byp_data  = i_data;
      o_byp_carry = i_cf;
      o_amount    = w_r;
      if (w_n == '0) begin
         if (!w_reg) begin
            case (w_op)
               SH_LSL: ;
               SH_LSR: begin o_byp_data = '0;               o_byp_carry = w_msb;     end
               SH_ASR: begin o_byp_data = {WIDTH{w_msb}};   o_byp_carry = w_msb;     end
               SH_ROR: begin o_byp_data = {i_cf, i_data[WIDTH-1:1]}; o_byp_carry = i_data[0]; end
            endcase
         end
      end else begin
         case (w_op)
            SH_LSL:
               if (w_n < W_N) begin
                  o_bypass = 1'b0;
                  o_amount = -w_r;
               end else begin
                  o_byp_data  = '0;
                  o_byp_carry = (w_n == W_N) ? i_data[0] : 1'b0;
               end
            SH_LSR:
               if (w_n < W_N) o_bypass = 1'b0;
               else begin
                  o_byp_data  = '0;
                  o_byp_carry = (w_n == W_N) ? w_msb : 1'b0;
               end
            SH_ASR:
               if (w_n < W_N) o_bypass = 1'b0;
               else begin
                  o_byp_data  = {WIDTH{w_msb}};
                  o_byp_carry = w_msb;
               end
            SH_ROR:
               if (w_r != '0) o_bypass = 1'b0;
               else o_byp_carry = w_msb;
         endcase
      end
   end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined ARM operand-2 barrel shifter with valid/ready handshake.
// Stage 1 decodes; rotate/mask mux levels are spread over the later stages.
module barrel_shifter_pipe
   import arm_shift_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_W  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Shift_Data,
   input  logic [NUM_W-1:0] Shift_Num,
   input  logic [2:0]       Shift_Op,
   input  logic             CF,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Shift_Out,
   output logic             Shift_Carry_Out
);

   localparam int L = $clog2(WIDTH);

   // cf holds the final carry for bypass beats and the ASR fill bit otherwise
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] mask;
      logic [L-1:0]     amount;
      logic [1:0]       op;
      logic             cf;
      logic             special;
   } stage_t;

   function automatic int level_stage(input int j);
      return (STAGES == 1) ? 2 : 2 + (j * (STAGES - 1)) / L;
   endfunction

   function automatic stage_t apply_levels(input stage_t p, input int stg);
      stage_t v = p;
      for (int j = 0; j < L; j++) begin
         if (level_stage(j) == stg && v.amount[j]) begin
            v.data = (v.data >> (1 << j)) | (v.data << (WIDTH - (1 << j)));
            v.mask = v.mask >> (1 << j);
         end
      end
      return v;
   endfunction

   // Carry is always a fixed bit of the rotated word: bit 0 for LSL, MSB otherwise
   function automatic logic [WIDTH:0] finish(input stage_t p);
      stage_t           v;
      logic [WIDTH-1:0] o;
      logic             c;
      v = apply_levels(p, STAGES + 1);
      o = v.data;
      c = v.data[WIDTH-1];
      if (v.special) c = v.cf;
      else begin
         case (shift_op_e'(v.op))
            SH_LSL: begin o = v.data & ~v.mask; c = v.data[0]; end
            SH_LSR: o = v.data & v.mask;
            SH_ASR: o = (v.data & v.mask) | ({WIDTH{v.cf}} & ~v.mask);
            default: ;
         endcase
      end
      return {o, c};
   endfunction

   logic             w_byp;
   logic [WIDTH-1:0] w_byp_data;
   logic             w_byp_carry;
   logic [L-1:0]     w_amt;

   shift_decode #(.WIDTH(WIDTH), .NUM_W(NUM_W)) u_dec (
      .i_data      (Shift_Data),
      .i_num       (Shift_Num),
      .i_op        (Shift_Op),
      .i_cf        (CF),
      .o_bypass    (w_byp),
      .o_byp_data  (w_byp_data),
      .o_byp_carry (w_byp_carry),
      .o_amount    (w_amt)
   );

   logic [STAGES:1] r_vld;
   stage_t          r_p   [1:STAGES];
   stage_t          w_pin [1:STAGES];
   logic [STAGES:1] w_vin;
   logic [STAGES:1] w_en;

   for (genvar k = 1; k <= STAGES; k++) begin : g_stg
      // stage k may load if any stage from k onward has a hole, or the output drains
      assign w_en[k] = out_ready | ~(&r_vld[STAGES:k]);
      if (k == 1) begin : g_first
         assign w_vin[k] = in_valid;
         assign w_pin[k] = '{data:    w_byp ? w_byp_data : Shift_Data,
                             mask:    {WIDTH{1'b1}},
                             amount:  w_byp ? {L{1'b0}} : w_amt,
                             op:      Shift_Op[2:1],
                             cf:      w_byp ? w_byp_carry : Shift_Data[WIDTH-1],
                             special: w_byp};
      end else begin : g_mux
         assign w_vin[k] = r_vld[k-1];
         assign w_pin[k] = apply_levels(r_p[k-1], k);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int k = 1; k <= STAGES; k++) r_p[k] <= '0;
      end else begin
         for (int k = 1; k <= STAGES; k++) begin
            if (w_en[k]) begin
               r_vld[k] <= w_vin[k];
               if (w_vin[k]) r_p[k] <= w_pin[k];
            end
         end
      end
   end

   assign in_ready  = w_en[1];
   assign out_valid = r_vld[STAGES];
   assign {Shift_Out, Shift_Carry_Out} = finish(r_p[STAGES]);

endmodule
